// File: rtl/noc_merge_pkg.sv
// Shared NoC merge/split definitions: the source-tag encoding lives here so the
// merge and the split that routes responses back can never disagree on it.
package noc_merge_pkg;

    localparam int CTRL_W = 2;

    typedef logic [CTRL_W-1:0] ctrl_t;

    localparam ctrl_t CTRL_IN0 = 2'd0;
    localparam ctrl_t CTRL_IN1 = 2'd1;

    // Tag for a granted input index (0 -> in0, 1 -> in1).
    function automatic ctrl_t port_tag(input logic idx);
        return idx ? CTRL_IN1 : CTRL_IN0;
    endfunction

endpackage

// File: rtl/merge_fifo2.sv
// Two-entry {ctrl, data} buffer for the merge output; the caller must not push
// while full or pop while empty.
module merge_fifo2
    import noc_merge_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  ctrl_t            push_ctrl,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output ctrl_t            head_ctrl,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count,
    output logic             full,
    output logic             empty
);

    ctrl_t            mem_ctrl [2];
    logic [WIDTH-1:0] mem_data [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count_q;

    // Storage is cleared too, so the head reads as zero straight out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_ctrl[0] <= CTRL_IN0;
            mem_ctrl[1] <= CTRL_IN0;
            mem_data[0] <= '0;
            mem_data[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            if (push) begin
                mem_ctrl[wr_ptr] <= push_ctrl;
                mem_data[wr_ptr] <= push_data;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_ctrl = mem_ctrl[rd_ptr];
    assign head_data = mem_data[rd_ptr];
    assign count     = count_q;
    assign full      = (count_q == 2'd2);
    assign empty     = (count_q == 2'd0);

endmodule

// File: rtl/arb_merge_2to1.sv
// Round-robin 2-to-1 merge: arbitrates two valid/ready sources into one output
// stream, tagging each word with its source for the downstream split.
module arb_merge_2to1
    import noc_merge_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    output logic [WIDTH-1:0] out_data,
    output ctrl_t            out_ctrl,
    output logic             out_valid,
    input  logic             out_ready
);

    if (DEPTH != 2) begin : g_depth_check
        $error("arb_merge_2to1: DEPTH must be 2");
    end

    logic             rr_ptr;
    logic             gnt0;
    logic             gnt1;
    logic             push;
    logic             pop;
    ctrl_t            push_ctrl;
    logic [WIDTH-1:0] push_data;
    logic [1:0]       count;
    logic             full;
    logic             empty;

    // Grant looks only at buffer occupancy and source valids, never out_ready,
    // so a full buffer blocks pushes even in a cycle that also pops.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset && !full) begin
            if (in0_valid && in1_valid) begin
                gnt0 = ~rr_ptr;
                gnt1 = rr_ptr;
            end else begin
                gnt0 = in0_valid;
                gnt1 = in1_valid;
            end
        end
    end

    assign push      = gnt0 | gnt1;
    assign push_ctrl = port_tag(gnt1);
    assign push_data = gnt1 ? in1_data : in0_data;
    assign pop       = !empty && out_ready;

    // After serving input k the other input wins the next tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= 1'b0;
        end else if (push) begin
            rr_ptr <= ~gnt1;
        end
    end

    merge_fifo2 #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_ctrl (push_ctrl),
        .push_data (push_data),
        .pop       (pop),
        .head_ctrl (out_ctrl),
        .head_data (out_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (count <= 2'd2);
        end
    end

    assign in0_ready = gnt0;
    assign in1_ready = gnt1;
    assign out_valid = !empty;

endmodule

// File: tb/tb_arb_merge_2to1.sv
// Bench for arb_merge_2to1: directed vector table, reset corner sequence, and a
// randomized run against a queue-based reference model.
module tb_arb_merge_2to1;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in0_data;
    logic       in0_valid;
    logic       in0_ready;
    logic [7:0] in1_data;
    logic       in1_valid;
    logic       in1_ready;
    logic [7:0] out_data;
    logic [1:0] out_ctrl;
    logic       out_valid;
    logic       out_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    arb_merge_2to1 #(.WIDTH(8), .DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in0_data  (in0_data),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in1_data  (in1_data),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       ordy;
        logic       r0;
        logic       r1;
        logic       ov;
        logic [7:0] od;
        logic [1:0] oc;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        in0_data  = '0;
        in1_data  = '0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Reference model state for the random run.
    logic [7:0] q_data [$];
    logic [1:0] q_ctrl [$];
    int         tie_winner;

    initial begin
        tbl[0]  = '{1, 8'h11, 0, 8'h00, 1, 1, 0, 0, 8'h00, 2'd0};
        tbl[1]  = '{1, 8'h22, 0, 8'h00, 1, 1, 0, 1, 8'h11, 2'd0};
        tbl[2]  = '{1, 8'h33, 0, 8'h00, 1, 1, 0, 1, 8'h22, 2'd0};
        tbl[3]  = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 8'h33, 2'd0};
        tbl[4]  = '{1, 8'hA0, 1, 8'hB0, 1, 0, 1, 0, 8'h00, 2'd0};
        tbl[5]  = '{1, 8'hA0, 1, 8'hB1, 1, 1, 0, 1, 8'hB0, 2'd1};
        tbl[6]  = '{1, 8'hA1, 1, 8'hB1, 1, 0, 1, 1, 8'hA0, 2'd0};
        tbl[7]  = '{1, 8'hA1, 1, 8'hB2, 1, 1, 0, 1, 8'hB1, 2'd1};
        tbl[8]  = '{1, 8'hA2, 1, 8'hB2, 0, 0, 1, 1, 8'hA1, 2'd0};
        tbl[9]  = '{1, 8'hA2, 1, 8'hB3, 0, 0, 0, 1, 8'hA1, 2'd0};
        tbl[10] = '{1, 8'hA2, 1, 8'hB3, 1, 0, 0, 1, 8'hA1, 2'd0};
        tbl[11] = '{1, 8'hA2, 1, 8'hB3, 0, 1, 0, 1, 8'hB2, 2'd1};
        tbl[12] = '{0, 8'h00, 1, 8'hB3, 1, 0, 0, 1, 8'hB2, 2'd1};
        tbl[13] = '{0, 8'h00, 1, 8'hB3, 1, 0, 1, 1, 8'hA2, 2'd0};
        tbl[14] = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 8'hB3, 2'd1};
        tbl[15] = '{0, 8'h00, 1, 8'h5A, 1, 0, 1, 0, 8'h00, 2'd0};
        tbl[16] = '{1, 8'hC0, 1, 8'hC1, 1, 1, 0, 1, 8'h5A, 2'd1};
        tbl[17] = '{0, 8'h00, 1, 8'hC1, 1, 0, 1, 1, 8'hC0, 2'd0};
        tbl[18] = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 8'hC1, 2'd1};
        tbl[19] = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 2'd0};

        // Reset state, with both sources requesting.
        reset     = 1'b1;
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        in0_data  = 8'h77;
        in1_data  = 8'h88;
        out_ready = 1'b1;
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_ctrl", out_ctrl, 2'd0);
        chk("rst_in0_ready", in0_ready, 1'b0);
        chk("rst_in1_ready", in1_ready, 1'b0);
        tick();
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        tick();
        reset = 1'b0;

        // Directed vectors, one per cycle.
        for (int i = 0; i < 20; i++) begin
            in0_valid = tbl[i].v0;
            in0_data  = tbl[i].d0;
            in1_valid = tbl[i].v1;
            in1_data  = tbl[i].d1;
            out_ready = tbl[i].ordy;
            #2;
            chk($sformatf("vec%0d_in0_ready", i), in0_ready, tbl[i].r0);
            chk($sformatf("vec%0d_in1_ready", i), in1_ready, tbl[i].r1);
            chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].ov);
            if (tbl[i].ov) begin
                chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].od);
                chk($sformatf("vec%0d_out_ctrl", i), out_ctrl, tbl[i].oc);
            end
            tick();
        end

        // Reset with two words buffered, then in0 must win the first tie.
        in0_valid = 1'b1;
        in0_data  = 8'hE0;
        in1_valid = 1'b1;
        in1_data  = 8'hE1;
        out_ready = 1'b0;
        tick();
        in0_data = 8'hE2;
        tick();
        #2;
        chk("mid_full_out_data", out_data, 8'hE0);
        chk("mid_full_in0_ready", in0_ready, 1'b0);
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_in0_ready", in0_ready, 1'b0);
        chk("mid_rst_in1_ready", in1_ready, 1'b0);
        chk("mid_rst_out_data", out_data, 8'h00);
        chk("mid_rst_out_ctrl", out_ctrl, 2'd0);
        tick();
        reset = 1'b0;
        #2;
        chk("post_rst_in0_ready", in0_ready, 1'b1);
        chk("post_rst_in1_ready", in1_ready, 1'b0);
        tick();
        in0_valid = 1'b0;
        #2;
        chk("post_rst_out_valid", out_valid, 1'b1);
        chk("post_rst_out_data", out_data, 8'hE2);
        chk("post_rst_out_ctrl", out_ctrl, 2'd0);

        // Randomized traffic against the queue model.
        do_reset();
        q_data.delete();
        q_ctrl.delete();
        tie_winner = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int grant;
            if (!in0_valid && $urandom_range(0, 3) != 0) begin
                in0_valid = 1'b1;
                in0_data  = 8'($urandom);
            end
            if (!in1_valid && $urandom_range(0, 3) != 0) begin
                in1_valid = 1'b1;
                in1_data  = 8'($urandom);
            end
            out_ready = ((cyc / 64) % 2 == 0) ? ($urandom_range(0, 7) != 0)
                                              : ($urandom_range(0, 2) == 0);
            #2;
            grant = -1;
            if (q_data.size() < 2) begin
                if (in0_valid && in1_valid) grant = tie_winner;
                else if (in0_valid)         grant = 0;
                else if (in1_valid)         grant = 1;
            end
            chk("rnd_in0_ready", in0_ready, grant == 0);
            chk("rnd_in1_ready", in1_ready, grant == 1);
            chk("rnd_out_valid", out_valid, q_data.size() != 0);
            if (q_data.size() != 0) begin
                chk("rnd_out_data", out_data, q_data[0]);
                chk("rnd_out_ctrl", out_ctrl, q_ctrl[0]);
            end
            @(posedge clk);
            if (q_data.size() != 0 && out_ready) begin
                void'(q_data.pop_front());
                void'(q_ctrl.pop_front());
            end
            if (grant == 0) begin
                q_data.push_back(in0_data);
                q_ctrl.push_back(2'd0);
                tie_winner = 1;
            end else if (grant == 1) begin
                q_data.push_back(in1_data);
                q_ctrl.push_back(2'd1);
                tie_winner = 0;
            end
            #1;
            if (grant == 0) in0_valid = 1'b0;
            if (grant == 1) in1_valid = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arb_merge_2to1.md
Name: arb_merge_2to1

Overview:
- Clocked 2-to-1 merge that performs the inverse of the NoC split stage: two input channels are arbitrated onto one output channel.
- Each output word carries a 2-bit control tag naming its source. The tag uses the split stage's encoding: 0 = port 0, 1 = port 1.
- A downstream split can route responses back using the tag.
- Round-robin fairness; a 2-entry output buffer sustains one word per cycle.

Parameters:
- WIDTH, 8, data width of every channel.
- DEPTH, 2, output buffer entries. Fixed at 2; any other value is a compile-time error.

Ports:
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- in0_data  input  WIDTH  data from source 0.
- in0_valid  input  1  source 0 holds a word.
- in0_ready  output  1  merge accepts source 0 this cycle.
- in1_data  input  WIDTH  data from source 1.
- in1_valid  input  1  source 1 holds a word.
- in1_ready  output  1  merge accepts source 1 this cycle.
- out_data  output  WIDTH  head-of-buffer data.
- out_ctrl  output  2  source tag of head word: 2'd0 = in0, 2'd1 = in1.
- out_valid  output  1  buffer non-empty.
- out_ready  input  1  sink accepts head word.

Behaviour:
- Transfer on any channel = valid && ready at a rising clk.
- Sources hold data stable and keep valid high until accepted. The merge never drops or duplicates a word.
- Reset (async assert, while reset=1):
  - count=0, rr_ptr=0 (in0 has priority).
  - out_valid=0, out_data=0, out_ctrl=0.
  - in0_ready=0, in1_ready=0.
- Reset mid-operation discards buffered words. No output transitions occur during reset.
- Grant (combinational from registered state and input valids):
  - When count==DEPTH: neither input ready.
  - Otherwise, only one valid: that input is granted.
  - Otherwise, both valid: the input indexed by rr_ptr is granted.
  - Otherwise, neither valid: no grant.
- At most one input accepted per cycle. inX_ready never depends on out_ready (no comb path sink to source).
- rr_ptr update: after a grant to input k, rr_ptr <= ~k. Without a grant, rr_ptr holds.
- Consequence: with both inputs valid continuously, grants strictly alternate.
- Buffer: FIFO of {ctrl, data}.
  - Push on grant with tag = granted index; pop on out_valid && out_ready.
  - Simultaneous push and pop at count==1: count stays 1, new word becomes head next cycle.
  - Push is blocked at count==2 even if pop occurs that cycle. Throughput is still 1 word/cycle at steady count 1.
- Latency: word accepted at edge N appears on out_* after edge N (visible cycle N+1) when the buffer was empty. Otherwise it appears in FIFO order.
- Output stability: out_data/out_ctrl/out_valid change only after a pop or a push to an empty buffer. Head is stable while out_valid && !out_ready.
- out_ctrl values 2'd2 and 2'd3 are never produced.
- Pointers: 1-bit read/write indices wrap 1->0. count is 2 bits, range 0..2, no overflow or underflow by construction.

Decomposition:
- Package noc_merge_pkg:
  - CTRL_W = 2.
  - CTRL_IN0 = 2'd0, CTRL_IN1 = 2'd1.
  - typedef ctrl_t (logic [CTRL_W-1:0]).
  - Shared with the split-side RTL so encodings cannot diverge.
- Sub-module merge_fifo2: 2-entry {ctrl, data} buffer with push/pop/count/full/empty, async active-high reset.
- Top level holds the arbiter and rr_ptr.

Test Plan:
- Reset: assert reset mid-stream with 2 words buffered -> out_valid=0, both ready=0 immediately; after release, first grant with both valid goes to in0.
- Single source: in0 sends 8'h11, 8'h22, 8'h33 with out_ready=1 -> outputs 11/22/33 in order, all out_ctrl=0, one word per cycle, first word one cycle after acceptance.
- Contention: both valid continuously (in0=8'hA0.., in1=8'hB0..), out_ready=1 -> out_ctrl sequence 0,1,0,1,...; each source accepted every other cycle.
- Backpressure: out_ready=0, both valid -> exactly 2 words accepted then both ready=0. Head held stable. Release out_ready -> both words drain in order, no loss.
- Simultaneous push/pop at count=1: confirm count stays 1 and order is preserved. Push attempt at count=2 with pop -> input not accepted that cycle.
- Fairness after idle: in1 alone sends 8'h5A (rr_ptr->0), then both valid -> in0 granted first.
